display_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the 4-digit, common-anode 7-segment display.
- Sequences the digit-select index through fixed slots, each with an anti-ghosting blank interval.
- Decodes hex nibbles to segments and drives the anodes.
- Takes display updates through a req/ack handshake and applies them only at frame boundaries, so a frame is never torn.
- Sits between the register/UI logic that produces display values and the board pins.

---
 rtl/display_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// display_scan_ctrl : 4-digit common-anode 7-seg scan with frame-synced update
// Revision 1.0
// ============================================================================
module display_scan_ctrl #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        upd_req,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  mask_in,
  output logic        upd_busy,
  output logic        upd_ack,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [1:0]  digit_sel,
  output logic        frame_start
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_BLANK = 2'd1;
  localparam logic [1:0] c_S_DRIVE = 2'd2;

  localparam int              c_CW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 2;
  localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK_CYC - 1);
  localparam logic [c_CW-1:0] c_SLOT_LAST  = c_CW'(PRESCALE - 1);

  logic [1:0]      r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]      r_sel, w_sel_nxt;
  logic            w_frame_nxt;

  logic [15:0] r_act_val, r_pend_val, w_act_val_nxt;
  logic [3:0]  r_act_dp, r_pend_dp, w_act_dp_nxt;
  logic [3:0]  r_act_mask, r_pend_mask, w_act_mask_nxt;
  logic        r_busy, r_ack, r_frame;
  logic        w_apply, w_capture;

  logic [3:0]  r_an_n, w_an_nxt;
  logic [6:0]  r_seg_n, w_seg_nxt;
  logic        r_dp_n, w_dp_nxt;
  logic [3:0]  w_nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // State register, prescaler, update path and registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_S_IDLE;
      r_cnt       <= '0;
      r_sel       <= 2'd0;
      r_frame     <= 1'b0;
      r_act_val   <= 16'h0;
      r_act_dp    <= 4'h0;
      r_act_mask  <= 4'h0;
      r_pend_val  <= 16'h0;
      r_pend_dp   <= 4'h0;
      r_pend_mask <= 4'h0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_an_n      <= 4'hF;
      r_seg_n     <= 7'h7F;
      r_dp_n      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_frame    <= w_frame_nxt;
      r_act_val  <= w_act_val_nxt;
      r_act_dp   <= w_act_dp_nxt;
      r_act_mask <= w_act_mask_nxt;
      r_ack      <= w_apply;
      if (w_capture) begin
        r_pend_val  <= value_in;
        r_pend_dp   <= dp_in;
        r_pend_mask <= mask_in;
      end
      if (w_apply)
        r_busy <= 1'b0;
      else if (w_capture)
        r_busy <= 1'b1;
      r_an_n  <= w_an_nxt;
      r_seg_n <= w_seg_nxt;
      r_dp_n  <= w_dp_nxt;
    end
  end

  // Next-state: slot counter runs 0..PRESCALE-1, first BLANK_CYC counts are blank
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_frame_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = c_S_IDLE;
      w_cnt_nxt   = '0;
      w_sel_nxt   = 2'd0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          w_state_nxt = c_S_BLANK;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 2'd0;
          w_frame_nxt = 1'b1;
        end
        c_S_BLANK: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == c_BLANK_LAST)
            w_state_nxt = c_S_DRIVE;
        end
        c_S_DRIVE: begin
          if (r_cnt == c_SLOT_LAST) begin
            w_state_nxt = c_S_BLANK;
            w_cnt_nxt   = '0;
            w_sel_nxt   = r_sel + 2'd1;
            w_frame_nxt = (r_sel == 2'd3);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = c_S_IDLE;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 2'd0;
        end
      endcase
    end
  end

  // A capture in the same cycle as an apply only lands in pending, never in active
  assign w_capture      = upd_req && !r_busy;
  assign w_apply        = r_busy && ((r_state == c_S_IDLE) || w_frame_nxt);
  assign w_act_val_nxt  = w_apply ? r_pend_val  : r_act_val;
  assign w_act_dp_nxt   = w_apply ? r_pend_dp   : r_act_dp;
  assign w_act_mask_nxt = w_apply ? r_pend_mask : r_act_mask;
  assign w_nib          = w_act_val_nxt[{w_sel_nxt, 2'b00} +: 4];

  // Output decode from the next state so pins change on the transition edge
  always_comb begin
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if ((w_state_nxt == c_S_DRIVE) && w_act_mask_nxt[w_sel_nxt]) begin
      w_an_nxt[w_sel_nxt] = 1'b0;
      w_seg_nxt           = hex_to_seg(w_nib);
      w_dp_nxt            = ~w_act_dp_nxt[w_sel_nxt];
    end
  end

  assign upd_busy    = r_busy;
  assign upd_ack     = r_ack;
  assign an_n        = r_an_n;
  assign seg_n       = r_seg_n;
  assign dp_n        = r_dp_n;
  assign digit_sel   = r_sel;
  assign frame_start = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// Directed testbench for display_scan_ctrl with PRESCALE=8, BLANK_CYC=2.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        upd_req;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  mask_in;
  logic        upd_busy;
  logic        upd_ack;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [1:0]  digit_sel;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  display_scan_ctrl #(.PRESCALE(8), .BLANK_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .upd_req(upd_req),
    .value_in(value_in), .dp_in(dp_in), .mask_in(mask_in),
    .upd_busy(upd_busy), .upd_ack(upd_ack), .an_n(an_n), .seg_n(seg_n),
    .dp_n(dp_n), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; upd_req = 1'b0;
    value_in = 16'h0; dp_in = 4'h0; mask_in = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({an_n, seg_n, dp_n, digit_sel, frame_start, upd_ack, upd_busy} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b sel=%0d fs=%b ack=%b busy=%b required an=f seg=7f dp=1 sel=0 fs=0 ack=0 busy=0",
               an_n, seg_n, dp_n, digit_sel, frame_start, upd_ack, upd_busy);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({an_n, seg_n, dp_n, digit_sel, frame_start} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL idle_after_reset: an=%h seg=%h dp=%b sel=%0d fs=%b required an=f seg=7f dp=1 sel=0 fs=0",
               an_n, seg_n, dp_n, digit_sel, frame_start);
    end
  endtask

  task automatic test_update_idle_scan();
    logic [6:0] seg_tab [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       lit;
    int s, c;
    seg_tab[0] = 7'h19; seg_tab[1] = 7'h30; seg_tab[2] = 7'h24; seg_tab[3] = 7'h79;
    upd_req = 1'b1; value_in = 16'h1234; mask_in = 4'hF; dp_in = 4'b0010;
    @(negedge clk);
    upd_req = 1'b0;
    n_cmp++;
    if ({upd_busy, upd_ack} !== 2'b10) begin
      n_err++;
      $display("FAIL idle_capture: busy=%b ack=%b required busy=1 ack=0", upd_busy, upd_ack);
    end
    @(negedge clk);
    n_cmp++;
    if ({upd_busy, upd_ack} !== 2'b01) begin
      n_err++;
      $display("FAIL idle_apply: busy=%b ack=%b required busy=0 ack=1", upd_busy, upd_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (upd_ack !== 1'b0) begin
      n_err++;
      $display("FAIL ack_one_cycle: ack=%b required 0", upd_ack);
    end
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      s = i / 8; c = i % 8;
      lit = (c >= 2);
      exp_an = 4'hF;
      if (lit) exp_an[s] = 1'b0;
      exp_seg = lit ? seg_tab[s] : 7'h7F;
      exp_dp = lit ? ~dp_in[s] : 1'b1;
      n_cmp++;
      if ({an_n, seg_n, dp_n, digit_sel, frame_start} !== {exp_an, exp_seg, exp_dp, s[1:0], (i == 0)}) begin
        n_err++;
        $display("FAIL scan_1234 i=%0d: an=%h seg=%h dp=%b sel=%0d fs=%b required an=%h seg=%h dp=%b sel=%0d fs=%b",
                 i, an_n, seg_n, dp_n, digit_sel, frame_start, exp_an, exp_seg, exp_dp, s, (i == 0));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL frame_period_32: fs=%b required 1", frame_start);
    end
  endtask

  task automatic test_mask();
    logic [6:0] seg_tab [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       lit;
    int s, c;
    seg_tab[0] = 7'h19; seg_tab[1] = 7'h30; seg_tab[2] = 7'h24; seg_tab[3] = 7'h79;
    upd_req = 1'b1; value_in = 16'h1234; mask_in = 4'b0101; dp_in = 4'b0000;
    @(negedge clk);
    upd_req = 1'b0;
    for (int k = 0; k < 40 && frame_start !== 1'b1; k++) @(negedge clk);
    n_cmp++;
    if ({frame_start, upd_ack, upd_busy} !== 3'b110) begin
      n_err++;
      $display("FAIL mask_apply: fs=%b ack=%b busy=%b required fs=1 ack=1 busy=0", frame_start, upd_ack, upd_busy);
    end
    for (int i = 0; i < 32; i++) begin
      s = i / 8; c = i % 8;
      lit = (c >= 2) && (s == 0 || s == 2);
      exp_an = 4'hF;
      if (lit) exp_an[s] = 1'b0;
      exp_seg = lit ? seg_tab[s] : 7'h7F;
      n_cmp++;
      if ({an_n, seg_n, dp_n, digit_sel, frame_start} !== {exp_an, exp_seg, 1'b1, s[1:0], (i == 0)}) begin
        n_err++;
        $display("FAIL scan_mask i=%0d: an=%h seg=%h dp=%b sel=%0d fs=%b required an=%h seg=%h dp=1 sel=%0d fs=%b",
                 i, an_n, seg_n, dp_n, digit_sel, frame_start, exp_an, exp_seg, s, (i == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    logic [6:0] seg_tab [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       lit;
    int s, c;
    int early = 0;
    seg_tab[0] = 7'h21; seg_tab[1] = 7'h46; seg_tab[2] = 7'h03; seg_tab[3] = 7'h08;
    repeat (10) @(negedge clk);
    upd_req = 1'b1; value_in = 16'hABCD; mask_in = 4'hF; dp_in = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (upd_busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_set: busy=%b required 1", upd_busy);
    end
    value_in = 16'hFFFF; dp_in = 4'hF;
    @(negedge clk);
    upd_req = 1'b0;
    for (int k = 0; k < 40 && frame_start !== 1'b1; k++) begin
      if (upd_busy !== 1'b1 || upd_ack !== 1'b0) early++;
      @(negedge clk);
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL busy_hold: early_clear_cycles=%0d required 0", early);
    end
    n_cmp++;
    if ({frame_start, upd_ack, upd_busy} !== 3'b110) begin
      n_err++;
      $display("FAIL ack_on_frame: fs=%b ack=%b busy=%b required fs=1 ack=1 busy=0", frame_start, upd_ack, upd_busy);
    end
    for (int i = 0; i < 32; i++) begin
      s = i / 8; c = i % 8;
      lit = (c >= 2);
      exp_an = 4'hF;
      if (lit) exp_an[s] = 1'b0;
      exp_seg = lit ? seg_tab[s] : 7'h7F;
      n_cmp++;
      if ({an_n, seg_n, dp_n, digit_sel} !== {exp_an, exp_seg, 1'b1, s[1:0]}) begin
        n_err++;
        $display("FAIL scan_abcd i=%0d: an=%h seg=%h dp=%b sel=%0d required an=%h seg=%h dp=1 sel=%0d",
                 i, an_n, seg_n, dp_n, digit_sel, exp_an, exp_seg, s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_drop();
    repeat (19) @(negedge clk);
    n_cmp++;
    if ({digit_sel, an_n, seg_n} !== {2'd2, 4'hB, 7'h03}) begin
      n_err++;
      $display("FAIL slot2_drive: sel=%0d an=%h seg=%h required sel=2 an=b seg=03", digit_sel, an_n, seg_n);
    end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({an_n, seg_n, dp_n, digit_sel} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL drop_idle: an=%h seg=%h dp=%b sel=%0d required an=f seg=7f dp=1 sel=0", an_n, seg_n, dp_n, digit_sel);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({an_n, digit_sel, frame_start} !== {4'hF, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL idle_hold: an=%h sel=%0d fs=%b required an=f sel=0 fs=0", an_n, digit_sel, frame_start);
    end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({frame_start, an_n, digit_sel} !== {1'b1, 4'hF, 2'd0}) begin
      n_err++;
      $display("FAIL restart: fs=%b an=%h sel=%0d required fs=1 an=f sel=0", frame_start, an_n, digit_sel);
    end
    @(negedge clk);
    n_cmp++;
    if ({frame_start, an_n} !== {1'b0, 4'hF}) begin
      n_err++;
      $display("FAIL restart_blank2: fs=%b an=%h required fs=0 an=f", frame_start, an_n);
    end
    @(negedge clk);
    n_cmp++;
    if ({an_n, seg_n} !== {4'hE, 7'h21}) begin
      n_err++;
      $display("FAIL restart_drive: an=%h seg=%h required an=e seg=21", an_n, seg_n);
    end
  endtask

  task automatic test_wrap_timing();
    int run [4];
    int done [4];
    int overlap = 0;
    int last_fs = -1;
    int fs_cnt = 0;
    int lows;
    for (int d = 0; d < 4; d++) begin run[d] = 0; done[d] = 0; end
    for (int k = 0; k < 40 && frame_start !== 1'b1; k++) @(negedge clk);
    for (int i = 0; i < 97; i++) begin
      lows = 0;
      for (int d = 0; d < 4; d++) begin
        if (an_n[d] === 1'b0) begin
          lows++;
          run[d]++;
        end else if (run[d] != 0) begin
          n_cmp++;
          if (run[d] !== 6) begin
            n_err++;
            $display("FAIL anode_run d=%0d: low_cycles=%0d required 6", d, run[d]);
          end
          done[d]++;
          run[d] = 0;
        end
      end
      if (lows > 1) overlap++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (i - last_fs !== 32) begin
            n_err++;
            $display("FAIL frame_spacing: cycles=%0d required 32", i - last_fs);
          end
        end
        last_fs = i;
        fs_cnt++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (overlap !== 0) begin
      n_err++;
      $display("FAIL anode_overlap: cycles=%0d required 0", overlap);
    end
    n_cmp++;
    if ({done[0], done[1], done[2], done[3], fs_cnt} !== {32'd3, 32'd3, 32'd3, 32'd3, 32'd4}) begin
      n_err++;
      $display("FAIL run_counts: runs=%0d,%0d,%0d,%0d frames=%0d required 3,3,3,3 frames=4",
               done[0], done[1], done[2], done[3], fs_cnt);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    upd_req = 1'b1; value_in = 16'h5678; mask_in = 4'hF; dp_in = 4'hF;
    @(negedge clk);
    upd_req = 1'b0;
    n_cmp++;
    if ({an_n, upd_busy} !== {4'hE, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset_drive: an=%h busy=%b required an=e busy=1", an_n, upd_busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({an_n, seg_n, dp_n, digit_sel, frame_start, upd_ack, upd_busy} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: an=%h seg=%h dp=%b sel=%0d fs=%b ack=%b busy=%b required an=f seg=7f dp=1 sel=0 fs=0 ack=0 busy=0",
               an_n, seg_n, dp_n, digit_sel, frame_start, upd_ack, upd_busy);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({an_n, seg_n, digit_sel, upd_busy, upd_ack} !== {4'hF, 7'h7F, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_idle: an=%h seg=%h sel=%0d busy=%b ack=%b required an=f seg=7f sel=0 busy=0 ack=0",
               an_n, seg_n, digit_sel, upd_busy, upd_ack);
    end
    // Active mask was cleared by reset, so a scan must stay dark
    enable = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({an_n, seg_n, digit_sel} !== {4'hF, 7'h7F, 2'd0}) begin
      n_err++;
      $display("FAIL reset_cleared_active: an=%h seg=%h sel=%0d required an=f seg=7f sel=0", an_n, seg_n, digit_sel);
    end
  endtask

  initial begin
    test_reset();
    test_update_idle_scan();
    test_mask();
    test_busy_ignore();
    test_enable_drop();
    test_wrap_timing();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
